ahb_slave_port_arbiter: RTL and testbench

- Round-robin arbiter for one AHB slave port shared by CHANNEL_NUM masters.
- Produces the one-hot address-phase select and the data-phase select for the master-side payload mux in front of that slave.
- Holds a grant for the whole of a defined-length burst and for locked sequences.
- Parks on a default master when nobody requests.

---
 rtl/ahb_slave_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ahb_slave_port_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_port_arbiter.sv
// Round-robin grant logic for one AHB slave port shared by CHANNEL_NUM masters.
// Grants are held across defined-length/INCR bursts and locked sequences; idle parks on DEFAULT_MASTER.
module ahb_slave_port_arbiter #(
  parameter int CHANNEL_NUM    = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [CHANNEL_NUM-1:0]         req,
  input  logic [CHANNEL_NUM-1:0]         lock,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  output logic [CHANNEL_NUM-1:0]         addr_sel,
  output logic [CHANNEL_NUM-1:0]         data_sel,
  output logic [$clog2(CHANNEL_NUM)-1:0] owner,
  output logic                           busy
);

  localparam int OW = $clog2(CHANNEL_NUM);
  localparam logic [OW-1:0] DEF_IDX = OW'(DEFAULT_MASTER);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          rr_q, rr_d;
  logic [3:0]             beats_q, beats_d;
  logic                   incr_q, incr_d;
  logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;

  logic                   rearb;
  logic                   start;
  logic                   found;
  logic [OW-1:0]          winner;
  logic [3:0]             burst_extra;

  // Beats remaining after the NONSEQ for defined-length bursts; 0 for SINGLE and INCR.
  always_comb begin
    unique case (hburst)
      3'b010, 3'b011: burst_extra = 4'd3;
      3'b100, 3'b101: burst_extra = 4'd7;
      3'b110, 3'b111: burst_extra = 4'd15;
      default:        burst_extra = 4'd0;
    endcase
  end

  // Round-robin search starting just after rr_q; the previous winner is examined last.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = DEF_IDX;
    for (int i = 1; i <= CHANNEL_NUM; i++) begin
      idx = (int'(rr_q) + i) % CHANNEL_NUM;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    beats_d    = beats_q;
    incr_d     = incr_q;
    data_sel_d = data_sel_q;
    rearb      = 1'b0;
    start      = 1'b0;

    if (hready) begin
      data_sel_d = htrans[1] ? addr_sel : '0;

      unique case (state_q)
        PARK: begin
          if (htrans == HT_NONSEQ) start = 1'b1;
          else                     rearb = 1'b1;
        end
        BURST: begin
          if (htrans == HT_NONSEQ) begin
            start = 1'b1;
          end else if (htrans == HT_SEQ) begin
            beats_d = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
            if (beats_q == 4'd1 || (incr_q && !req[owner_q])) begin
              state_d = PARK;
              incr_d  = 1'b0;
              rearb   = 1'b1;
            end
          end else if (htrans == HT_IDLE) begin
            state_d = PARK;
            incr_d  = 1'b0;
            rearb   = 1'b1;
          end
          // HT_BUSY: hold everything.
        end
        LOCK: begin
          if (!lock[owner_q] && htrans == HT_IDLE) begin
            state_d = PARK;
            rearb   = 1'b1;
          end
        end
        default: begin
          state_d = PARK;
          rearb   = 1'b1;
        end
      endcase

      if (start) begin
        if (lock[owner_q]) begin
          state_d = LOCK;
          incr_d  = 1'b0;
        end else if (burst_extra != 4'd0) begin
          state_d = BURST;
          beats_d = burst_extra;
          incr_d  = 1'b0;
        end else if (hburst == HB_INCR) begin
          state_d = BURST;
          beats_d = 4'd0;
          incr_d  = 1'b1;
        end else begin
          state_d = PARK;
          incr_d  = 1'b0;
          rearb   = 1'b1;
        end
      end

      if (rearb) begin
        owner_d = found ? winner : DEF_IDX;
        if (found) rr_d = winner;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (HRESET) begin
      state_q    <= PARK;
      owner_q    <= DEF_IDX;
      rr_q       <= DEF_IDX;
      beats_q    <= 4'd0;
      incr_q     <= 1'b0;
      data_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      beats_q    <= beats_d;
      incr_q     <= incr_d;
      data_sel_q <= data_sel_d;
    end
  end

  // addr_sel is a decode of the binary owner, so it can never be multi-hot.
  always_comb begin
    addr_sel          = '0;
    addr_sel[owner_q] = 1'b1;
  end

  assign owner    = owner_q;
  assign data_sel = data_sel_q;
  assign busy     = (state_q != PARK);

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed-vector bench: the driver queues hand-computed post-edge expectations,
// and a monitor compares them against the DUT just after each rising edge.
module tb_ahb_slave_port_arbiter;

  localparam int N = 3;

  localparam logic [1:0] IDLE = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] req, lock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] addr_sel, data_sel;
  logic [1:0]   owner;
  logic         busy;

  typedef struct {
    string        name;
    logic [N-1:0] addr;
    logic [N-1:0] data;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ahb_slave_port_arbiter #(.CHANNEL_NUM(N), .DEFAULT_MASTER(0)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .req      (req),
    .lock     (lock),
    .htrans   (htrans),
    .hburst   (hburst),
    .hready   (hready),
    .addr_sel (addr_sel),
    .data_sel (data_sel),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs ahead of the next rising edge and queue the expected result.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic [1:0] t, input logic [2:0] b, input logic rdy,
                      input logic [N-1:0] ea, input logic [N-1:0] ed, input logic eb,
                      input string nm);
    exp_t e;
    @(negedge HCLK);
    HRESET = rst;
    req    = r;
    lock   = l;
    htrans = t;
    hburst = b;
    hready = rdy;
    e.name = nm;
    e.addr = ea;
    e.data = ed;
    e.busy = eb;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare 1 time unit after each rising edge.
  always @(posedge HCLK) begin
    exp_t e;
    logic [1:0] eo;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      eo = '0;
      for (int i = 0; i < N; i++) if (e.addr[i]) eo = 2'(i);
      check({e.name, ".addr_sel"}, 32'(addr_sel), 32'(e.addr));
      check({e.name, ".data_sel"}, 32'(data_sel), 32'(e.data));
      check({e.name, ".owner"},    32'(owner),    32'(eo));
      check({e.name, ".busy"},     32'(busy),     32'(e.busy));
    end
  end

  initial begin
    HRESET = 1'b1; req = '0; lock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;

    // Reset with all requests pending, then first grant goes to master 1.
    step(1, 3'b111, 3'b000, IDLE, SINGLE, 1, 3'b001, 3'b000, 0, "reset0");
    step(1, 3'b111, 3'b000, IDLE, SINGLE, 1, 3'b001, 3'b000, 0, "reset1");
    step(0, 3'b111, 3'b000, IDLE, SINGLE, 1, 3'b010, 3'b000, 0, "first_grant");

    // Round-robin over SINGLE NONSEQs; data_sel trails addr_sel by one cycle.
    step(0, 3'b111, 3'b000, NS, SINGLE, 1, 3'b100, 3'b010, 0, "rr_a");
    step(0, 3'b111, 3'b000, NS, SINGLE, 1, 3'b001, 3'b100, 0, "rr_b");
    step(0, 3'b111, 3'b000, NS, SINGLE, 1, 3'b010, 3'b001, 0, "rr_c");
    step(0, 3'b111, 3'b000, NS, SINGLE, 1, 3'b100, 3'b010, 0, "rr_d");

    // INCR4 by master 2 with a BUSY inserted.
    step(0, 3'b011, 3'b000, NS,  INCR4, 1, 3'b100, 3'b100, 1, "incr4_ns");
    step(0, 3'b011, 3'b000, SQ,  INCR4, 1, 3'b100, 3'b100, 1, "incr4_s1");
    step(0, 3'b011, 3'b000, BSY, INCR4, 1, 3'b100, 3'b000, 1, "incr4_busy");
    step(0, 3'b011, 3'b000, SQ,  INCR4, 1, 3'b100, 3'b100, 1, "incr4_s2");
    step(0, 3'b011, 3'b000, SQ,  INCR4, 1, 3'b001, 3'b100, 0, "incr4_s3");

    // INCR8 by master 1 with three wait states on beat 4 and owner req dropped.
    step(0, 3'b010, 3'b000, IDLE, SINGLE, 1, 3'b010, 3'b000, 0, "incr8_grant");
    step(0, 3'b010, 3'b000, NS, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b1");
    step(0, 3'b010, 3'b000, SQ, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b2");
    step(0, 3'b010, 3'b000, SQ, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b3");
    step(0, 3'b111, 3'b000, SQ, INCR8, 0, 3'b010, 3'b010, 1, "incr8_wait1");
    step(0, 3'b111, 3'b000, SQ, INCR8, 0, 3'b010, 3'b010, 1, "incr8_wait2");
    step(0, 3'b111, 3'b000, SQ, INCR8, 0, 3'b010, 3'b010, 1, "incr8_wait3");
    step(0, 3'b101, 3'b000, SQ, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b4");
    step(0, 3'b101, 3'b000, SQ, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b5");
    step(0, 3'b101, 3'b000, SQ, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b6");
    step(0, 3'b101, 3'b000, SQ, INCR8, 1, 3'b010, 3'b010, 1, "incr8_b7");
    step(0, 3'b101, 3'b000, SQ, INCR8, 1, 3'b100, 3'b010, 0, "incr8_b8");

    // Park on default, then a locked sequence by master 0.
    step(0, 3'b000, 3'b000, IDLE, SINGLE, 1, 3'b001, 3'b000, 0, "park");
    step(0, 3'b110, 3'b001, NS,   SINGLE, 1, 3'b001, 3'b001, 1, "lock_ns1");
    step(0, 3'b110, 3'b001, NS,   SINGLE, 1, 3'b001, 3'b001, 1, "lock_ns2");
    step(0, 3'b110, 3'b001, IDLE, SINGLE, 1, 3'b001, 3'b000, 1, "lock_idle");
    step(0, 3'b110, 3'b000, NS,   SINGLE, 1, 3'b001, 3'b001, 1, "unlock_ns");
    step(0, 3'b110, 3'b000, IDLE, SINGLE, 1, 3'b010, 3'b000, 0, "unlock_idle");

    // Park, then reset during beat 2 of a WRAP4 by master 2.
    step(0, 3'b000, 3'b000, IDLE, SINGLE, 1, 3'b001, 3'b000, 0, "park2");
    step(0, 3'b100, 3'b000, IDLE, SINGLE, 1, 3'b100, 3'b000, 0, "wrap4_grant");
    step(0, 3'b100, 3'b000, NS,   WRAP4,  1, 3'b100, 3'b100, 1, "wrap4_ns");
    step(1, 3'b100, 3'b000, SQ,   WRAP4,  1, 3'b001, 3'b000, 0, "wrap4_reset");
    step(0, 3'b101, 3'b000, IDLE, SINGLE, 1, 3'b100, 3'b000, 0, "post_reset_rr");

    // INCR burst ended by an ERROR-style wait followed by IDLE.
    step(0, 3'b101, 3'b000, NS,   INCR, 1, 3'b100, 3'b100, 1, "incr_ns");
    step(0, 3'b101, 3'b000, SQ,   INCR, 1, 3'b100, 3'b100, 1, "incr_seq");
    step(0, 3'b101, 3'b000, SQ,   INCR, 0, 3'b100, 3'b100, 1, "err_wait");
    step(0, 3'b101, 3'b000, IDLE, INCR, 1, 3'b001, 3'b000, 0, "err_idle");

    // INCR burst ended by the owner dropping req.
    step(0, 3'b011, 3'b000, NS,   INCR,   1, 3'b001, 3'b001, 1, "incr2_ns");
    step(0, 3'b010, 3'b000, SQ,   INCR,   1, 3'b010, 3'b001, 0, "incr2_drop");
    step(0, 3'b000, 3'b000, IDLE, SINGLE, 1, 3'b001, 3'b000, 0, "final_park");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge HCLK);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
